// File: rtl/hack_screen_mem_pkg.sv
// hack_screen_mem_pkg: shared sizes and fill FSM encoding for the Hack screen memory
package hack_screen_mem_pkg;
  localparam int SCREEN_ADDR_W = 13;
  localparam int SCREEN_DATA_W = 16;
  localparam int SCREEN_DEPTH = 8192;
  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} fill_state_e;
endpackage

// File: rtl/hack_screen_ram.sv
// hack_screen_ram: framebuffer array, one sync write, one registered read, one async read
module hack_screen_ram
  import hack_screen_mem_pkg::*;
#(
  parameter int ADDR_W = SCREEN_ADDR_W,
  parameter int DATA_W = SCREEN_DATA_W,
  parameter int DEPTH = SCREEN_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  input  logic [ADDR_W-1:0] i_aaddr,
  output logic [DATA_W-1:0] o_adata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge i_clk) if (i_we) mem_q[i_waddr] <= i_wdata;
  always_ff @(posedge i_clk) o_rdata <= i_rst ? '0 : mem_q[i_raddr];
  assign o_adata = mem_q[i_aaddr];
endmodule

// File: rtl/hack_screen_mem.sv
// hack_screen_mem: Hack screen framebuffer with CPU port, VGA scan-out port and fill engine
module hack_screen_mem
  import hack_screen_mem_pkg::*;
#(
  parameter int ADDR_W = SCREEN_ADDR_W,
  parameter int DATA_W = SCREEN_DATA_W,
  parameter int DEPTH = SCREEN_DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic              i_cpu_we,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  input  logic              i_fill_req,
  input  logic [DATA_W-1:0] i_fill_data,
  output logic              o_busy,
  output logic              o_fill_done,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic [DATA_W-1:0] o_vga_data
);
  fill_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic done_q, done_d, filling, last;
  always_comb begin
    filling = state_q == FILL;
    last = filling && ptr_q == ADDR_W'(DEPTH - 1);
    state_d = filling ? (last ? IDLE : FILL) : (i_fill_req ? FILL : IDLE);
    ptr_d = filling ? ptr_q + 1'b1 : '0;
    pat_d = !filling && i_fill_req ? i_fill_data : pat_q;
    done_d = last;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q <= '0;
      pat_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      pat_q <= pat_d;
      done_q <= done_d;
    end
  end
  assign o_busy = filling;
  assign o_fill_done = done_q;
  // the fill engine owns the write port while active, so CPU writes are dropped
  hack_screen_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (filling | i_cpu_we),
    .i_waddr(filling ? ptr_q : i_cpu_addr),
    .i_wdata(filling ? pat_q : i_cpu_wdata),
    .i_raddr(i_cpu_addr),
    .o_rdata(o_cpu_rdata),
    .i_aaddr(i_vga_addr),
    .o_adata(o_vga_data)
  );
endmodule

// File: tb/tb_hack_screen_mem.sv
// tb_hack_screen_mem: directed and random checks of the screen memory against an array model
module tb_hack_screen_mem;
  localparam int DEPTH = 8192;
  logic i_clk = 1'b0;
  logic i_rst;
  logic [12:0] i_cpu_addr;
  logic i_cpu_we;
  logic [15:0] i_cpu_wdata;
  logic [15:0] o_cpu_rdata;
  logic i_fill_req;
  logic [15:0] i_fill_data;
  logic o_busy;
  logic o_fill_done;
  logic [12:0] i_vga_addr;
  logic [15:0] o_vga_data;
  logic [15:0] mdl [DEPTH];
  bit known [DEPTH];
  int tests = 0;
  int fails = 0;
  int bcnt = 0;
  int dcnt = 0;
  hack_screen_mem dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_cpu_addr (i_cpu_addr),
    .i_cpu_we   (i_cpu_we),
    .i_cpu_wdata(i_cpu_wdata),
    .o_cpu_rdata(o_cpu_rdata),
    .i_fill_req (i_fill_req),
    .i_fill_data(i_fill_data),
    .o_busy     (o_busy),
    .o_fill_done(o_fill_done),
    .i_vga_addr (i_vga_addr),
    .o_vga_data (o_vga_data)
  );
  always #20 i_clk = ~i_clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge i_clk);
    #1;
    if (o_busy) bcnt++;
    if (o_fill_done) dcnt++;
  endtask
  task automatic wr(input int a, input logic [15:0] d);
    i_cpu_addr = 13'(a);
    i_cpu_wdata = d;
    i_cpu_we = 1'b1;
    tick();
    i_cpu_we = 1'b0;
    mdl[a] = d;
    known[a] = 1'b1;
  endtask
  task automatic rd(input string tag, input int a);
    i_cpu_addr = 13'(a);
    tick();
    chk({tag, "_cpu"}, 32'(o_cpu_rdata), 32'(mdl[a]));
    i_vga_addr = 13'(a);
    #1;
    chk({tag, "_vga"}, 32'(o_vga_data), 32'(mdl[a]));
  endtask
  task automatic start_fill(input logic [15:0] p);
    i_fill_req = 1'b1;
    i_fill_data = p;
    bcnt = 0;
    dcnt = 0;
    tick();
    i_fill_req = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int g = 0;
    while (o_busy && g < 9000) begin
      tick();
      g++;
    end
    chk({tag, "_idle"}, 32'(o_busy), 32'd0);
  endtask
  task automatic fill_model(input logic [15:0] p);
    for (int i = 0; i < DEPTH; i++) begin
      mdl[i] = p;
      known[i] = 1'b1;
    end
  endtask
  initial begin
    int a, va, bad;
    logic w;
    logic [15:0] d, e;
    bit kn;
    i_rst = 1'b1;
    i_cpu_addr = '0;
    i_cpu_we = 1'b0;
    i_cpu_wdata = '0;
    i_fill_req = 1'b0;
    i_fill_data = '0;
    i_vga_addr = '0;
    tick();
    tick();
    chk("rst_rdata", 32'(o_cpu_rdata), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_fill_done), 32'd0);
    i_rst = 1'b0;
    i_vga_addr = 13'h0005;
    wr(5, 16'h1234);
    chk("vga_after_wr", 32'(o_vga_data), 32'h1234);
    rd("wr_rd_5", 5);
    wr(16'h10, 16'h1234);
    i_cpu_addr = 13'h10;
    i_cpu_wdata = 16'hBEEF;
    i_cpu_we = 1'b1;
    tick();
    i_cpu_we = 1'b0;
    chk("rbw_old", 32'(o_cpu_rdata), 32'h1234);
    tick();
    chk("rbw_new", 32'(o_cpu_rdata), 32'hBEEF);
    mdl[16] = 16'hBEEF;
    for (int i = 0; i < 64; i++) wr(i, 16'($urandom));
    for (int i = 0; i < 200; i++) begin
      a = $urandom_range(0, 63);
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      e = mdl[a];
      kn = known[a];
      i_cpu_addr = 13'(a);
      i_cpu_we = w;
      i_cpu_wdata = d;
      tick();
      i_cpu_we = 1'b0;
      if (kn) chk("rand_cpu", 32'(o_cpu_rdata), 32'(e));
      if (w) mdl[a] = d;
      va = $urandom_range(0, 63);
      i_vga_addr = 13'(va);
      #1;
      if (known[va]) chk("rand_vga", 32'(o_vga_data), 32'(mdl[va]));
    end
    start_fill(16'hFFFF);
    wait_idle("fill1");
    chk("fill1_len", 32'(bcnt), 32'd8192);
    chk("fill1_done_now", 32'(o_fill_done), 32'd1);
    tick();
    chk("fill1_done_pulse", 32'(o_fill_done), 32'd0);
    chk("fill1_done_cnt", 32'(dcnt), 32'd1);
    fill_model(16'hFFFF);
    rd("fill1_0000", 0);
    rd("fill1_0fff", 16'h0FFF);
    rd("fill1_1fff", 16'h1FFF);
    start_fill(16'hAAAA);
    repeat (16'h200) tick();
    i_cpu_addr = 13'h0100;
    i_cpu_wdata = 16'h0000;
    i_cpu_we = 1'b1;
    i_fill_req = 1'b1;
    i_fill_data = 16'h1111;
    tick();
    i_cpu_we = 1'b0;
    i_fill_req = 1'b0;
    i_cpu_addr = 13'h0050;
    tick();
    chk("midfill_rd_filled", 32'(o_cpu_rdata), 32'hAAAA);
    i_cpu_addr = 13'h1F00;
    tick();
    chk("midfill_rd_old", 32'(o_cpu_rdata), 32'hFFFF);
    wait_idle("fill2");
    chk("fill2_len", 32'(bcnt), 32'd8192);
    chk("fill2_done_cnt", 32'(dcnt), 32'd1);
    fill_model(16'hAAAA);
    rd("fill2_drop_0100", 16'h0100);
    rd("fill2_1fff", 16'h1FFF);
    wr(16'h0050, 16'h0000);
    wr(16'h0100, 16'h0000);
    start_fill(16'h5555);
    repeat (100) tick();
    i_rst = 1'b1;
    tick();
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_rdata", 32'(o_cpu_rdata), 32'd0);
    i_rst = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 32'(dcnt), 32'd0);
    for (int i = 0; i < 100; i++) mdl[i] = 16'h5555;
    known[100] = 1'b0;
    rd("abort_0050", 16'h0050);
    rd("abort_0063", 16'h0063);
    rd("abort_0065", 16'h0065);
    rd("abort_0100", 16'h0100);
    start_fill(16'hC3C3);
    wait_idle("fill3");
    chk("fill3_len", 32'(bcnt), 32'd8192);
    chk("fill3_done_now", 32'(o_fill_done), 32'd1);
    start_fill(16'h0F0F);
    chk("b2b_nogap", 32'(o_busy), 32'd1);
    wait_idle("fill4");
    chk("fill4_len", 32'(bcnt), 32'd8192);
    chk("fill4_done_cnt", 32'(dcnt), 32'd1);
    fill_model(16'h0F0F);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      i_vga_addr = 13'(i);
      #1;
      if (o_vga_data !== 16'h0F0F) bad++;
    end
    chk("fill4_sweep_bad", 32'(bad), 32'd0);
    for (int i = 0; i < 8; i++) rd("fill4_rand", $urandom_range(0, DEPTH - 1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
